// File: rtl/ln_iter_if.sv
// Request/result bundle for the ln_iter natural-log unit.
// The requester drives start/x0; the unit returns y/done/busy/err.
interface ln_iter_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic [W-1:0] x0;
  logic [W-1:0] y;
  logic         done;
  logic         busy;
  logic         err;

  modport master (output start, output x0, input y, input done, input busy, input err);
  modport slave  (input start, input x0, output y, output done, output busy, output err);
endinterface

// File: rtl/ln_iter.sv
// Natural logarithm of an unsigned fixed-point operand.
// Method: normalise, then shift-add multiplicative refinement with a table of ln(1+2^-i).
module ln_iter #(
  parameter int unsigned W = 16,
  parameter int unsigned F = 12,
  parameter int unsigned N = 12,
  parameter int unsigned G = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  ln_iter_if.slave io_bus
);

  localparam int unsigned FG = F + G;
  localparam int unsigned LW = FG + 1;
  localparam int unsigned PW = $clog2(W);
  localparam int unsigned KW = $clog2(W + F + 1) + 1;
  localparam int unsigned IW = $clog2(N + 1);
  localparam int unsigned XW = W + FG;
  localparam int unsigned RW = KW + LW + 2;

  localparam logic [LW-1:0]        ONE  = {1'b1, {FG{1'b0}}};
  localparam logic signed [RW-1:0] RND  = RW'(1) <<< (G - 1);
  localparam logic signed [RW-1:0] YMAX = RW'((64'd1 << (W - 1)) - 64'd1);
  localparam logic signed [RW-1:0] YMIN = ~YMAX;

  // ln(1+2^-idx) for idx>0, ln 2 for idx=0, via integer series at 60 fractional bits,
  // rounded to nearest at FG fractional bits.
  function automatic logic [LW-1:0] ln_const(input int unsigned idx);
    logic [63:0] acc;
    logic [63:0] term;
    int unsigned sh;
    acc = '0;
    for (int unsigned n = 1; n <= 60; n++) begin
      sh = (idx == 0) ? n : n * idx;
      if (sh < 60) begin
        term = (64'd1 << (60 - sh)) / 64'(n);
        if (idx != 0 && (n % 2) == 0) acc = acc - term;
        else                          acc = acc + term;
      end
    end
    return LW'((acc + (64'd1 << (59 - FG))) >> (60 - FG));
  endfunction

  typedef enum logic [1:0] {IDLE, NORM, ITER, FIN} state_t;

  state_t               r_state;
  logic [W-1:0]         r_x;
  logic [LW-1:0]        r_m;
  logic [LW-1:0]        r_s;
  logic signed [KW-1:0] r_k;
  logic [IW-1:0]        r_i;
  logic                 r_zero;
  logic [W-1:0]         r_y;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_err;

  logic [LW-1:0]        w_tab [N+1];
  logic [PW-1:0]        w_p;
  logic [LW-1:0]        w_m0;
  logic signed [KW-1:0] w_k;
  logic [LW-1:0]        w_t;
  logic signed [RW-1:0] w_r;
  logic signed [RW-1:0] w_rr;
  logic [W-1:0]         w_y;
  logic                 w_accept;

  for (genvar g = 0; g <= int'(N); g++) begin : g_tab
    localparam logic [LW-1:0] C = ln_const(g);
    assign w_tab[g] = C;
  end

  // Normalisation: MSB position, mantissa in [0.5,1) and binary exponent.
  always_comb begin
    w_p = '0;
    for (int b = 0; b < int'(W); b++) begin
      if (r_x[b]) w_p = PW'(b);
    end
    w_m0 = LW'((XW'(r_x) << FG) >> (32'(w_p) + 32'd1));
    w_k  = KW'(int'(w_p) + 1 - int'(F));
  end

  assign w_t      = r_m + (r_m >> r_i);
  assign w_accept = io_bus.start && (r_state == IDLE || r_state == FIN);

  // Final combine k*ln2 - S, round half-up to F bits, saturate to W bits.
  always_comb begin
    w_r  = RW'(r_k) * $signed(RW'(w_tab[0])) - $signed(RW'(r_s));
    w_rr = (w_r + RND) >>> G;
    if (r_zero)           w_y = {1'b1, {(W-1){1'b0}}};
    else if (w_rr > YMAX) w_y = W'(YMAX);
    else if (w_rr < YMIN) w_y = W'(YMIN);
    else                  w_y = W'(w_rr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_m     <= '0;
      r_s     <= '0;
      r_k     <= '0;
      r_i     <= '0;
      r_zero  <= 1'b0;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_x     <= io_bus.x0;
        r_s     <= '0;
        r_zero  <= 1'b0;
        r_busy  <= 1'b1;
        r_state <= NORM;
      end
      unique case (r_state)
        IDLE: ;
        NORM: begin
          if (r_x == '0) begin
            r_zero  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_m     <= w_m0;
            r_k     <= w_k;
            r_i     <= IW'(1);
            r_state <= ITER;
          end
        end
        ITER: begin
          if (w_t <= ONE) begin
            r_m <= w_t;
            r_s <= r_s + w_tab[r_i];
          end
          if (r_i == IW'(N)) r_state <= FIN;
          else               r_i     <= r_i + IW'(1);
        end
        FIN: begin
          r_y    <= w_y;
          r_err  <= r_zero;
          r_done <= 1'b1;
          if (!io_bus.start) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign io_bus.y    = r_y;
  assign io_bus.done = r_done;
  assign io_bus.busy = r_busy;
  assign io_bus.err  = r_err;

endmodule

// File: tb/tb_ln_iter.sv
// Directed bench for ln_iter: latency, results against hand-computed logs, zero/saturation,
// back-to-back restarts and mid-operation reset.
module tb_ln_iter;
  localparam int unsigned W = 16;
  localparam int unsigned F = 12;
  localparam int unsigned N = 12;
  localparam int unsigned G = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  ln_iter_if #(.W(W)) bus ();

  ln_iter #(.W(W), .F(F), .N(N), .G(G)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_chk++;
    if (got >= exp - tol && got <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, exp, tol);
  endtask

  function automatic int ys();
    return int'($signed(bus.y));
  endfunction

  // One operation; start lingers in NORM and is re-pulsed in ITER, x0 is scrambled after accept.
  task automatic run_op(input string tag, input logic [15:0] x, input int ey, input int tol,
                        input int eerr);
    int  lat;
    bit  seen;
    bus.start = 1'b1;
    bus.x0    = x;
    @(posedge clk); #1;
    check({tag, ".busy"}, int'(bus.busy), 1, 0);
    bus.x0 = ~x;
    lat  = -1;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
      bus.start = (x != 16'h0) && (c >= 3) && (c < 5);
      if (bus.done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    bus.start = 1'b0;
    check({tag, ".lat"}, lat, (x == 16'h0) ? 2 : int'(N) + 2, 0);
    check({tag, ".y"}, ys(), ey, tol);
    check({tag, ".err"}, int'(bus.err), eerr, 0);
    check({tag, ".idle"}, int'(bus.busy), 0, 0);
    @(posedge clk); #1;
    check({tag, ".pulse"}, int'(bus.done), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_done [3];
    int y_done [3];
    int np;
    int b_first;
    bit seen;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x0    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.y", ys(), 0, 0);
    check("rst.done", int'(bus.done), 0, 0);
    check("rst.busy", int'(bus.busy), 0, 0);
    check("rst.err", int'(bus.err), 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("one",   16'h1000,      0, 2, 0);
    run_op("p8",    16'h0CCD,   -914, 2, 0);
    run_op("eight", 16'h8000,   8517, 2, 0);
    run_op("ffff",  16'hFFFF,  11356, 2, 0);
    run_op("tiny",  16'h0001, -32768, 0, 0);
    run_op("two",   16'h2000,   2839, 2, 0);
    run_op("half",  16'h0800,  -2839, 2, 0);
    run_op("three", 16'h0003, -29570, 2, 0);
    run_op("e",     16'h2B7E,   4096, 2, 0);
    run_op("zero",  16'h0000, -32768, 0, 1);
    run_op("clr",   16'h1000,      0, 2, 0);

    // start held high: restarts in FIN with whatever x0 is present at that edge
    np      = 0;
    b_first = -1;
    bus.start = 1'b1;
    bus.x0    = 16'h1000;
    @(posedge clk); #1;
    bus.x0 = 16'h8000;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (bus.done && np < 3) begin
        t_done[np] = c;
        y_done[np] = ys();
        if (np == 0) b_first = int'(bus.busy);
        np++;
      end
      if (c == 14) bus.x0 = 16'h0CCD;
      if (c == 28) bus.start = 1'b0;
    end
    check("b2b.count", np, 3, 0);
    check("b2b.busy", b_first, 1, 0);
    if (np == 3) begin
      check("b2b.t0", t_done[0], 14, 0);
      check("b2b.t1", t_done[1], 28, 0);
      check("b2b.t2", t_done[2], 42, 0);
      check("b2b.y0", y_done[0], 0, 2);
      check("b2b.y1", y_done[1], 8517, 2);
      check("b2b.y2", y_done[2], -914, 2);
    end
    check("b2b.idle", int'(bus.busy), 0, 0);

    // reset in ITER after an x0=0 result so y/err are nonzero beforehand
    run_op("zero2", 16'h0000, -32768, 0, 1);
    bus.start = 1'b1;
    bus.x0    = 16'h8000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    check("abort.y", ys(), 0, 0);
    check("abort.done", int'(bus.done), 0, 0);
    check("abort.busy", int'(bus.busy), 0, 0);
    check("abort.err", int'(bus.err), 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("abort.quiet", int'(seen), 0, 0);

    run_op("after", 16'h0CCD, -914, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ln_iter.md
LN_ITER -- requirements
Module: ln_iter

Interface
REQ-001 Parameter W, default 16: total width of x0 and y.
REQ-002 Parameter F, default 12: fractional bits of x0 (unsigned) and y (signed two's complement).
REQ-003 Parameter N, default 12: number of refinement iterations (1..F+G).
REQ-004 Parameter G, default 4: internal guard fractional bits beyond F.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  request; sampled only when busy=0.
REQ-008 x0  in  W  operand, unsigned fixed point, value x0/2^F.
REQ-009 y  out  W  result ln(x), signed, F fractional bits; held until next accepted start.
REQ-010 done  out  1  one-cycle pulse: y valid.
REQ-011 busy  out  1  high while an operation is in flight.
REQ-012 err  out  1  high with done when x0=0; held with y.

Function
REQ-013 The block SHALL use FSM states IDLE, NORM, ITER, FIN.
REQ-014 IDLE, start=1: register x0, clear accumulator, busy=1, go to NORM.
REQ-015 NORM, one cycle: p = index of x0 MSB; m = x0/2^(p+1) in [0.5,1), held with F+G fractional bits; k = p+1-F (signed); i=1; go to ITER.
REQ-016 NORM with x0=0: go to FIN, result forced to most-negative y (1 followed by zeros), err=1.
REQ-017 ITER, one cycle per i: t = m + (m >> i) (shift-add, no multiplier); if t <= 1.0 (exact internal compare) then m=t and S = S + L[i]; else m, S unchanged; each i tried exactly once.
REQ-018 After i=N: go to FIN.
REQ-019 L[i] = ln(1+2^-i), i=1..N, and LN2 = ln 2: constants rounded to nearest at F+G fractional bits, fixed at elaboration.
REQ-020 FIN: r = k*LN2 - S at F+G fractional bits, widened so no intermediate overflow; round half-up to F bits; saturate to signed W range; register into y; done=1 for this cycle only; busy=0.
REQ-021 Latency: done is high exactly N+2 cycles after the start-accepting edge (x0=0: 2 cycles).
REQ-022 FIN SHALL accept start (back-to-back): start=1 in FIN behaves as in IDLE; otherwise go to IDLE.
REQ-023 start while busy=1 (NORM, ITER) SHALL be ignored; x0 changes during an operation SHALL not affect it.
REQ-024 Results below -2^(W-F-1) (tiny x0) SHALL saturate to most-negative, err=0; above max positive to most-positive.
REQ-025 Accuracy for nonzero x0 without saturation: |y - round(ln(x)*2^F)| <= 2 LSB at default parameters.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, y=0, done=0, busy=0, err=0, clear internal m, S, k, i; overrides start.
REQ-027 rst mid-operation SHALL abandon it; no done pulse for the aborted operation.

Verification (defaults W=16, F=12, N=12, G=4)
REQ-028 x0=0x1000 (1.0), start one cycle -> done 14 cycles later, y within 0x0000 +/-2, err=0.
REQ-029 x0=0x0CCD (0.8) -> y within 0xFC6E (-914) +/-2; x0=0x8000 (8.0) -> y within 0x2145 (8517) +/-2.
REQ-030 x0=0 -> done 2 cycles after start, y=0x8000, err=1; next valid op clears err.
REQ-031 x0=0x0001 -> y=0x8000 (saturated), err=0; x0=0xFFFF -> y within 0x2C5C (11356) +/-2.
REQ-032 start held high through op: second op starts in FIN cycle, done pulses every 14 cycles; rst asserted in ITER -> all outputs 0 next cycle, no done.
